// File: rtl/sym_vn_lut_loader.sv
// Purpose : pairs a serial stream of 4-bit IB-LUT entries into bank0/bank1 page writes for sym_vn_lut_in.
// Latency : one page write every 3 cycles at full rate; done pulses 3*PAGE_NUM+1 cycles after start.
// Backpressure: in_valid low stalls the load indefinitely; in_ready drops during the page-write cycle.
//
// Ports:
//   write_clk, rstn          clock (rising edge) and async active-low reset
//   start/start_offset/commit  begin a load of one offset half; commit flips the read half on done
//   abort                    cancel the load in progress (no rollback of pages already written)
//   in_data/in_valid/in_ready  entry stream, index order k = {y0[2:0], y1[3:0]}
//   lut_in_bank0/1, page_write_addr, write_addr_offset, we   page write port
//   read_addr_offset         active read half seen by sym_vn_lut_in
//   busy, done               load in progress, 1-cycle completion pulse
module sym_vn_lut_loader #(
  parameter int DATA_W   = 4,
  parameter int PAGE_NUM = 64,
  parameter int PAGE_AW  = 6
) (
  input  logic               write_clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               start_offset,
  input  logic               commit,
  input  logic               abort,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  lut_in_bank0,
  output logic [DATA_W-1:0]  lut_in_bank1,
  output logic [PAGE_AW-1:0] page_write_addr,
  output logic               write_addr_offset,
  output logic               we,
  output logic               read_addr_offset,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVEN,
    S_ODD,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [PAGE_AW-1:0] LAST_PAGE = PAGE_AW'(PAGE_NUM - 1);

  state_t              state;
  logic [PAGE_AW-1:0]  page;
  logic [DATA_W-1:0]   even_q;    // bank0 entry held until its odd partner arrives
  logic                commit_q;

  // All outputs are registered: each transition sets the values that belong
  // to the state being entered, so in_ready/busy/we/done never glitch.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state             <= S_IDLE;
      page              <= '0;
      even_q            <= '0;
      commit_q          <= 1'b0;
      in_ready          <= 1'b0;
      lut_in_bank0      <= '0;
      lut_in_bank1      <= '0;
      page_write_addr   <= '0;
      write_addr_offset <= 1'b0;
      we                <= 1'b0;
      read_addr_offset  <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            write_addr_offset <= start_offset;
            commit_q          <= commit;
            page              <= '0;
            in_ready          <= 1'b1;
            busy              <= 1'b1;
            state             <= S_EVEN;
          end
        end
        S_EVEN: begin
          if (abort) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (in_valid) begin
            even_q <= in_data;
            state  <= S_ODD;
          end
        end
        S_ODD: begin
          // abort wins over a simultaneous accept: the pair is dropped
          if (abort) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (in_valid) begin
            lut_in_bank0    <= even_q;
            lut_in_bank1    <= in_data;
            page_write_addr <= page;
            we              <= 1'b1;
            in_ready        <= 1'b0;
            state           <= S_WR;
          end
        end
        S_WR: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (page == LAST_PAGE) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            page     <= page + PAGE_AW'(1);
            in_ready <= 1'b1;
            state    <= S_EVEN;
          end
        end
        S_DONE: begin
          if (commit_q) read_addr_offset <= write_addr_offset;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Purpose : directed self-checking bench for sym_vn_lut_loader.
// Latency : checks full-rate (193 cycles) and 1/0-toggled (257 cycles) load timing.
// Backpressure: drives in_valid patterns and aborts/resets mid-load.
module tb_sym_vn_lut_loader;

  logic       write_clk;
  logic       rstn;
  logic       start;
  logic       start_offset;
  logic       commit;
  logic       abort;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] lut_in_bank0;
  logic [3:0] lut_in_bank1;
  logic [5:0] page_write_addr;
  logic       write_addr_offset;
  logic       we;
  logic       read_addr_offset;
  logic       busy;
  logic       done;

  sym_vn_lut_loader #(.DATA_W(4), .PAGE_NUM(64), .PAGE_AW(6)) dut (
    .write_clk         (write_clk),
    .rstn              (rstn),
    .start             (start),
    .start_offset      (start_offset),
    .commit            (commit),
    .abort             (abort),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .lut_in_bank0      (lut_in_bank0),
    .lut_in_bank1      (lut_in_bank1),
    .page_write_addr   (page_write_addr),
    .write_addr_offset (write_addr_offset),
    .we                (we),
    .read_addr_offset  (read_addr_offset),
    .busy              (busy),
    .done              (done)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Write-port monitor: records every we pulse just after the rising edge.
  logic [5:0] wr_pg  [1024];
  logic [3:0] wr_b0  [1024];
  logic [3:0] wr_b1  [1024];
  logic       wr_off [1024];
  int  wr_n       = 0;
  int  done_n     = 0;
  int  rdy_in_wr  = 0;
  int  dbl_we     = 0;
  bit  prev_we    = 0;

  always @(posedge write_clk) begin
    #1;
    if (we === 1'b1) begin
      if (wr_n < 1024) begin
        wr_pg[wr_n]  = page_write_addr;
        wr_b0[wr_n]  = lut_in_bank0;
        wr_b1[wr_n]  = lut_in_bank1;
        wr_off[wr_n] = write_addr_offset;
      end
      wr_n++;
      if (in_ready === 1'b1) rdy_in_wr++;
      if (prev_we) dbl_we++;
    end
    prev_we = (we === 1'b1);
    if (done === 1'b1) done_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares the writes captured since base against the k[3:0] data ramp.
  task automatic check_writes(input string tag, input int base, input int cnt, input logic off);
    int bad;
    bad = 0;
    chk({tag, "_we_count"}, wr_n - base, cnt);
    for (int i = 0; i < cnt; i++) begin
      int idx;
      idx = base + i;
      if (idx >= wr_n || idx >= 1024) bad++;
      else if (wr_pg[idx] !== 6'(i) || wr_b0[idx] !== 4'((2 * i) & 15) ||
               wr_b1[idx] !== 4'((2 * i + 1) & 15) || wr_off[idx] !== off) bad++;
    end
    chk({tag, "_write_contents_bad"}, bad, 0);
  endtask

  // Runs one load from the current negedge. Inputs change on negedges only.
  task automatic run_load(input logic off, input logic cmt, input bit toggle,
                          input int abort_pg, input int rst_pg, input int stray_at,
                          output int ncyc, output bit saw_done);
    int   k;
    logic rdy;
    logic vld;
    k = 0;
    ncyc = 0;
    saw_done = 0;
    start = 1'b1;
    start_offset = off;
    commit = cmt;
    in_valid = 1'b0;
    abort = 1'b0;
    @(negedge write_clk);
    ncyc = 1;
    start = 1'b0;
    while (ncyc < 1000) begin
      if (done === 1'b1) begin
        saw_done = 1;
        break;
      end
      if (abort_pg >= 0 && k == 2 * abort_pg + 1 && in_ready === 1'b1) begin
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = 4'hF;
        @(negedge write_clk);
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy_next", busy, 0);
        chk("abort_in_ready_next", in_ready, 0);
        break;
      end
      if (rst_pg >= 0 && we === 1'b1 && k == 2 * rst_pg + 2) begin
        rstn = 1'b0;
        #1;
        chk("midreset_we", we, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_rao", read_addr_offset, 0);
        break;
      end
      start = (ncyc == stray_at);
      start_offset = start ? ~off : off;
      commit = start ? 1'b1 : cmt;
      rdy = in_ready;
      vld = toggle ? ((ncyc % 2) == 1) : 1'b1;
      in_valid = vld;
      in_data = 4'(k);
      @(negedge write_clk);
      ncyc++;
      if (vld && rdy) k++;
    end
    start = 1'b0;
    start_offset = 1'b0;
    commit = 1'b0;
    in_valid = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    int  d0;
    int  r0;
    int  nc;
    bit  sd;
    rstn = 1'b1;
    start = 1'b0;
    start_offset = 1'b0;
    commit = 1'b0;
    abort = 1'b0;
    in_data = 4'h0;
    in_valid = 1'b0;
    #2 rstn = 1'b0;

    // Reset state
    @(negedge write_clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rao", read_addr_offset, 0);
    chk("rst_wao", write_addr_offset, 0);
    chk("rst_page", page_write_addr, 0);
    chk("rst_bank0", lut_in_bank0, 0);
    chk("rst_bank1", lut_in_bank1, 0);
    rstn = 1'b1;
    @(negedge write_clk);
    chk("idle_in_ready", in_ready, 0);

    // Full load, offset 1, commit
    base = wr_n;
    d0 = done_n;
    run_load(1'b1, 1'b1, 1'b0, -1, -1, -1, nc, sd);
    chk("full_done_seen", sd, 1);
    chk("full_cycles", nc, 193);
    chk("full_wao_at_done", write_addr_offset, 1);
    chk("full_rao_during_done", read_addr_offset, 0);
    @(negedge write_clk);
    chk("full_rao_after", read_addr_offset, 1);
    chk("full_busy_after", busy, 0);
    chk("full_done_one_cycle", done, 0);
    chk("full_done_pulses", done_n - d0, 1);
    check_writes("full", base, 64, 1'b1);

    // Reset in the page-10 write cycle
    base = wr_n;
    run_load(1'b0, 1'b1, 1'b0, -1, 10, -1, nc, sd);
    @(negedge write_clk);
    rstn = 1'b1;
    @(negedge write_clk);
    chk("postreset_in_ready", in_ready, 0);
    chk("postreset_busy", busy, 0);
    check_writes("midreset", base, 11, 1'b0);

    // No commit, plus a stray start while busy
    base = wr_n;
    d0 = done_n;
    run_load(1'b1, 1'b0, 1'b0, -1, -1, 50, nc, sd);
    chk("nocommit_done_seen", sd, 1);
    chk("nocommit_cycles", nc, 193);
    @(negedge write_clk);
    chk("nocommit_rao", read_addr_offset, 0);
    chk("nocommit_done_pulses", done_n - d0, 1);
    check_writes("nocommit", base, 64, 1'b1);

    // Backpressure: in_valid toggles 1/0
    base = wr_n;
    r0 = rdy_in_wr;
    d0 = dbl_we;
    run_load(1'b1, 1'b1, 1'b1, -1, -1, -1, nc, sd);
    chk("bp_done_seen", sd, 1);
    chk("bp_cycles", nc, 257);
    @(negedge write_clk);
    chk("bp_rao", read_addr_offset, 1);
    chk("bp_ready_in_wr", rdy_in_wr - r0, 0);
    chk("bp_back_to_back_we", dbl_we - d0, 0);
    check_writes("bp", base, 64, 1'b1);

    // Abort in ODD of page 5 (abort beats a simultaneous accept)
    base = wr_n;
    d0 = done_n;
    run_load(1'b0, 1'b1, 1'b0, 5, -1, -1, nc, sd);
    repeat (3) @(negedge write_clk);
    chk("abort_no_done", done_n - d0, 0);
    chk("abort_rao_unchanged", read_addr_offset, 1);
    chk("abort_busy_idle", busy, 0);
    check_writes("abort", base, 5, 1'b0);

    // Back-to-back loads: second start in the cycle right after done
    run_load(1'b1, 1'b1, 1'b0, -1, -1, -1, nc, sd);
    chk("b2b_first_done_seen", sd, 1);
    @(negedge write_clk);
    chk("b2b_rao_mid", read_addr_offset, 1);
    base = wr_n;
    run_load(1'b0, 1'b1, 1'b0, -1, -1, -1, nc, sd);
    chk("b2b_second_done_seen", sd, 1);
    chk("b2b_second_cycles", nc, 193);
    @(negedge write_clk);
    chk("b2b_rao_end", read_addr_offset, 0);
    check_writes("b2b", base, 64, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
